decoder_addr_sequencer: RTL and testbench

//  Upstream driver for the 2-to-4 behavioural/structural decoder: queues 2-bit address

---
 rtl/decoder_addr_sequencer.sv | 163 ++++++++++++++++
 tb/tb_decoder_addr_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_addr_sequencer.sv
// Request FIFO + phase FSM that drives a 2-to-4 decoder with stable address around each enable pulse.
// Optional SCAN_MODE_EN adds scan_en and an internal wrapping scan address used when the FIFO is empty.
module decoder_addr_sequencer #(
  parameter int DEPTH          = 4,
  parameter int SETUP_CYCLES   = 1,
  parameter int HOLD_CYCLES    = 4,
  parameter int RECOVER_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  input  logic [1:0]               req_addr,
`ifdef SCAN_MODE_EN
  input  logic                     scan_en,
`endif
  output logic                     req_ready,
  output logic                     addr0,
  output logic                     addr1,
  output logic                     enable,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int MAX_C = (SETUP_CYCLES > HOLD_CYCLES) ?
                         ((SETUP_CYCLES > RECOVER_CYCLES) ? SETUP_CYCLES : RECOVER_CYCLES) :
                         ((HOLD_CYCLES > RECOVER_CYCLES) ? HOLD_CYCLES : RECOVER_CYCLES);
  localparam int CNT_W = (MAX_C < 2) ? 1 : $clog2(MAX_C);

  typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, RECOVER} state_t;

  state_t             state, next_state;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [1:0]         mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               push, pop, launch;
  logic [1:0]         launch_addr;
`ifdef SCAN_MODE_EN
  logic [1:0]         scan_ptr;
  logic               scan_launch;
`endif

  assign req_ready = (level < LVL_W'(DEPTH));
  assign push      = req_valid & req_ready;
  assign busy      = (state != IDLE);

  // FIFO storage carries no reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_addr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_comb begin
    next_state  = state;
    cnt_next    = cnt;
    pop         = 1'b0;
    launch      = 1'b0;
    launch_addr = 2'b00;
`ifdef SCAN_MODE_EN
    scan_launch = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (level != '0) begin
          pop         = 1'b1;
          launch      = 1'b1;
          launch_addr = mem[rd_ptr];
          next_state  = SETUP;
          cnt_next    = CNT_W'(SETUP_CYCLES - 1);
        end
`ifdef SCAN_MODE_EN
        else if (scan_en) begin
          scan_launch = 1'b1;
          launch      = 1'b1;
          launch_addr = scan_ptr;
          next_state  = SETUP;
          cnt_next    = CNT_W'(SETUP_CYCLES - 1);
        end
`endif
      end
      SETUP: begin
        if (cnt == '0) begin
          next_state = ACTIVE;
          cnt_next   = CNT_W'(HOLD_CYCLES - 1);
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      ACTIVE: begin
        if (cnt == '0) begin
          next_state = RECOVER;
          cnt_next   = CNT_W'(RECOVER_CYCLES - 1);
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      RECOVER: begin
        if (cnt == '0) begin
          next_state = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: begin
        next_state = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  // Outputs are registered from next_state so they align exactly with the phase they belong to
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr0  <= 1'b0;
      addr1  <= 1'b0;
      enable <= 1'b0;
      done   <= 1'b0;
    end else begin
      if (launch) begin
        addr0 <= launch_addr[0];
        addr1 <= launch_addr[1];
      end
      enable <= (next_state == ACTIVE);
      done   <= (next_state == RECOVER) && (state != RECOVER);
    end
  end

`ifdef SCAN_MODE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) scan_ptr <= 2'b00;
    else if (scan_launch) scan_ptr <= scan_ptr + 2'b01;
  end
`endif

endmodule

// File: tb/tb_decoder_addr_sequencer.sv
// Scoreboard bench for decoder_addr_sequencer: accepted requests queue expected addresses,
// a monitor pops one per enable pulse. Define SCAN_MODE_EN to also exercise the scan feature.
module tb_decoder_addr_sequencer;

  logic       clk;
  logic       reset_n;
  logic       req_valid;
  logic [1:0] req_addr;
  logic       req_ready;
  logic       addr0, addr1, enable, busy, done;
  logic [2:0] level;
`ifdef SCAN_MODE_EN
  logic       scan_en;
`endif

  int         checks = 0;
  int         errors = 0;
  int         n_pulses = 0;
  logic [1:0] exp_q[$];

  decoder_addr_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
`ifdef SCAN_MODE_EN
    .scan_en   (scan_en),
`endif
    .req_ready (req_ready),
    .addr0     (addr0),
    .addr1     (addr1),
    .enable    (enable),
    .busy      (busy),
    .done      (done),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the push.
  task automatic do_push(input logic [1:0] a);
    bit ok;
    ok = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (ok) exp_q.push_back(a);
    else timeout_fail("push_accept");
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 120 && !ok; n++) begin
      @(negedge clk);
      if (level == 3'd0 && !busy && !enable) ok = 1'b1;
    end
    if (!ok) timeout_fail("drain");
    @(posedge clk);
    #1;
  endtask

  // Monitor: one expected address consumed per enable pulse; width and done timing checked too
  initial begin : monitor
    logic       prev_en;
    int         hi;
    logic [2:0] cur_exp;
    prev_en = 1'b0;
    hi      = 0;
    cur_exp = 3'd4;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_en = 1'b0;
        hi      = 0;
      end else begin
        if (enable && !prev_en) begin
          n_pulses++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            cur_exp = 3'd4;
            $display("FAIL unexpected_pulse: addr %0d with empty scoreboard at %0t", {addr1, addr0}, $time);
          end else begin
            cur_exp = {1'b0, exp_q.pop_front()};
          end
        end
        if (enable) begin
          hi++;
          if (cur_exp != 3'd4) chk("pulse_addr", {addr1, addr0}, cur_exp);
        end
        if (!enable && prev_en) begin
          chk("pulse_width", hi, 4);
          chk("done_after_pulse", done, 1);
          hi = 0;
        end
        prev_en = enable;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic exp_en [8];
    logic exp_dn [8];
    logic exp_bz [8];
    bit   found;
    int   base;

    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_addr  = 2'b00;
`ifdef SCAN_MODE_EN
    scan_en   = 1'b0;
`endif
    exp_en = '{0, 0, 1, 1, 1, 1, 0, 0};
    exp_dn = '{0, 0, 0, 0, 0, 0, 1, 0};
    exp_bz = '{0, 1, 1, 1, 1, 1, 1, 0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_addr",  {addr1, addr0}, 0);
    chk("rst_enable", enable, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_level", level, 0);
    chk("rst_ready", req_ready, 1);
    @(posedge clk);
    #1;

    // Single request 2'b10: cycle-accurate timeline from acceptance
    do_push(2'b10);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t2_enable", enable, exp_en[k]);
      chk("t2_done",   done,   exp_dn[k]);
      chk("t2_busy",   busy,   exp_bz[k]);
      if (k >= 1) chk("t2_addr", {addr1, addr0}, 2);
    end
    chk("t2_level", level, 0);
    wait_idle();

    // Back-to-back 3,0,1,2,3 fills the FIFO; sixth waits for room
    do_push(2'd3);
    do_push(2'd0);
    do_push(2'd1);
    do_push(2'd2);
    do_push(2'd3);
    @(negedge clk);
    chk("t3_level_full", level, 4);
    chk("t3_ready_full", req_ready, 0);
    @(posedge clk);
    #1;
    do_push(2'd0);
    wait_idle();

    // Push coinciding with a pop at level 3, then a push while full
    do_push(2'd1);
    do_push(2'd2);
    do_push(2'd3);
    do_push(2'd0);
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (!busy && level == 3'd3) found = 1'b1;
    end
    if (!found) timeout_fail("t4_idle_l3");
    req_valid = 1'b1;
    req_addr  = 2'd2;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    exp_q.push_back(2'd2);
    chk("t4_level_pushpop", level, 3);
    chk("t4_busy", busy, 1);
    do_push(2'd1);
    req_valid = 1'b1;
    req_addr  = 2'd3;
    @(negedge clk);
    chk("t4_ready_full", req_ready, 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("t4_level_ignored", level, 4);
    wait_idle();

    // Reset in the second ACTIVE cycle with two requests still queued
    do_push(2'd2);
    do_push(2'd3);
    do_push(2'd0);
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (enable) found = 1'b1;
    end
    if (!found) timeout_fail("t5_first_active");
    chk("t5_level_before", level, 2);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_enable", enable, 0);
    chk("t5_level", level, 0);
    chk("t5_busy", busy, 0);
    chk("t5_addr", {addr1, addr0}, 0);
    exp_q.delete();
    base = n_pulses;
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    @(negedge clk);
    chk("t5_no_pulses", n_pulses, base);
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_level", level, 0);
    @(posedge clk);
    #1;

`ifdef SCAN_MODE_EN
    // Scan 0,1 then a queued request preempts before scan continues 2,3,0
    base = n_pulses;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    scan_en = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (n_pulses >= base + 2) found = 1'b1;
    end
    if (!found) timeout_fail("t6_scan_two");
    @(posedge clk);
    #1;
    do_push(2'd3);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge clk);
      if (n_pulses >= base + 6) found = 1'b1;
    end
    if (!found) timeout_fail("t6_scan_rest");
    scan_en = 1'b0;
    wait_idle();
    chk("t6_pulses", n_pulses, base + 6);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
